// File: rtl/bus_pkg.sv
// Shared types for the CPU external-bus memory responder.
//   word_t      64-bit bus data word
//   tag_t       8-bit tag carried alongside each word
//   bus_word_t  stored/returned unit {tag, data}
package bus_pkg;

  typedef logic [63:0] word_t;
  typedef logic [7:0]  tag_t;

  typedef struct packed {
    tag_t  tag;
    word_t data;
  } bus_word_t;

  localparam int BUS_WORD_W     = $bits(bus_word_t);
  localparam int BUS_RD_LAT_MAX = 4;

endpackage

// File: rtl/bus_mem_array.sv
// Single-port synchronous storage for bus_memory.
//   clk    clock
//   reset  async active-high; clears only the read register, never mem
//   we     write enable, stores wdata at addr
//   re     read enable, registers mem[addr] into rdata (pipeline stage 0)
//   addr   word address
//   wdata  {tag, data} to store
//   rdata  registered read word
// The storage array keeps its contents across reset so benches can
// preload it hierarchically through mem.
module bus_mem_array
  import bus_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [AW-1:0]         addr,
  input  logic [BUS_WORD_W-1:0] wdata,
  output logic [BUS_WORD_W-1:0] rdata
);

  bus_word_t mem [2**AW];
  bus_word_t rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register sees the array as it was before any same-edge write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/bus_memory.sv
// Memory responder for the CPU external bus.
//   clk      clock
//   reset    async active-high; clears all registers except storage
//   i_ad     address on strobe / write data on write
//   i_tag    write tag
//   i_astb   address strobe, i_ad[AW-1:0] is the word address
//   i_rd     read request
//   i_wr     write request
//   o_data   read data (held between pulses)
//   o_tag    read tag (held between pulses)
//   o_valid  one-cycle pulse on new read data
//   o_err    sticky flag, set when i_rd and i_wr are both high
// Reads return after RD_LAT cycles; writes take one cycle. Every access
// post-increments the address register for bursts, wrapping modulo 2**AW.
module bus_memory
  import bus_pkg::*;
#(
  parameter int AW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_ad,
  input  logic [7:0]  i_tag,
  input  logic        i_astb,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic [63:0] o_data,
  output logic [7:0]  o_tag,
  output logic        o_valid,
  output logic        o_err
);

  generate
    if (RD_LAT < 1 || RD_LAT > BUS_RD_LAT_MAX) begin : g_bad_lat
      $error("bus_memory: RD_LAT must be in 1..%0d", BUS_RD_LAT_MAX);
    end
  endgenerate

  logic [AW-1:0]     addr_reg;
  logic [AW-1:0]     addr_next;
  logic [AW-1:0]     eff_addr;
  logic              rd_fire;
  logic              wr_fire;
  logic              conflict;
  logic [RD_LAT-1:0] valid_reg;
  logic              last_valid;
  bus_word_t         rd_word;
  bus_word_t         last_word;
  bus_word_t         wr_word;

  assign rd_fire  = i_rd & ~i_wr;
  assign wr_fire  = i_wr & ~i_rd;
  assign conflict = i_rd & i_wr;
  assign wr_word  = '{tag: i_tag, data: i_ad};

  // A strobe in the same cycle as an access redirects that access.
  // A conflicting rd+wr performs no access, so only a strobe can move addr.
  always_comb begin
    eff_addr  = i_astb ? i_ad[AW-1:0] : addr_reg;
    addr_next = eff_addr;
    if (rd_fire || wr_fire) begin
      addr_next = eff_addr + AW'(1);
    end
  end

  bus_mem_array #(
    .AW(AW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (wr_fire),
    .re    (rd_fire),
    .addr  (eff_addr),
    .wdata (wr_word),
    .rdata (rd_word)
  );

  // Stage 0 data lives in the array's read register; stages 1..RD_LAT-1
  // are delay registers here.
  generate
    if (RD_LAT == 1) begin : g_no_stages
      assign last_word = rd_word;
    end else begin : g_stages
      bus_word_t stage_reg [RD_LAT-1];
      for (genvar gi = 0; gi < RD_LAT - 1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
              stage_reg[0] <= '0;
            end else begin
              stage_reg[0] <= rd_word;
            end
          end
        end else begin : g_next
          always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
              stage_reg[gi] <= '0;
            end else begin
              stage_reg[gi] <= stage_reg[gi-1];
            end
          end
        end
      end
      assign last_word = stage_reg[RD_LAT-2];
    end
  endgenerate

  assign last_valid = valid_reg[RD_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg  <= '0;
      o_err     <= 1'b0;
      valid_reg <= '0;
      o_data    <= '0;
      o_tag     <= '0;
      o_valid   <= 1'b0;
    end else begin
      addr_reg <= addr_next;
      if (conflict) begin
        o_err <= 1'b1;
      end
      for (int i = RD_LAT - 1; i > 0; i--) begin
        valid_reg[i] <= valid_reg[i-1];
      end
      valid_reg[0] <= rd_fire;
      o_valid      <= last_valid;
      if (last_valid) begin
        o_data <= last_word.data;
        o_tag  <= last_word.tag;
      end
    end
  end

endmodule

// File: tb/tb_bus_memory.sv
// Randomised and directed bench for bus_memory. Three instances share the
// same stimulus (AW=16/RD_LAT=1, AW=16/RD_LAT=3, AW=4/RD_LAT=2); each is
// compared against a calendar-style reference model: a read issued before
// edge N schedules its word to appear after edge N+RD_LAT.
module tb_bus_memory;

  localparam int NDUT = 3;
  localparam int LAT_K [NDUT] = '{1, 3, 2};
  localparam int AW_K  [NDUT] = '{16, 16, 4};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] i_ad = '0;
  logic [7:0]  i_tag = '0;
  logic        i_astb = 1'b0;
  logic        i_rd = 1'b0;
  logic        i_wr = 1'b0;

  logic [63:0] od [NDUT];
  logic [7:0]  ot [NDUT];
  logic        ov [NDUT];
  logic        oe [NDUT];

  always #5 clk = ~clk;

  bus_memory #(.AW(16), .RD_LAT(1)) d0 (
    .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
    .i_rd(i_rd), .i_wr(i_wr), .o_data(od[0]), .o_tag(ot[0]),
    .o_valid(ov[0]), .o_err(oe[0]));

  bus_memory #(.AW(16), .RD_LAT(3)) d1 (
    .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
    .i_rd(i_rd), .i_wr(i_wr), .o_data(od[1]), .o_tag(ot[1]),
    .o_valid(ov[1]), .o_err(oe[1]));

  bus_memory #(.AW(4), .RD_LAT(2)) d2 (
    .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
    .i_rd(i_rd), .i_wr(i_wr), .o_data(od[2]), .o_tag(ot[2]),
    .o_valid(ov[2]), .o_err(oe[2]));

  // Reference model state
  logic [71:0] mm [NDUT][65536];
  int          addr_m [NDUT];
  bit          err_m [NDUT];
  logic [71:0] out_m [NDUT];
  bit          sched_v [NDUT][8];
  logic [71:0] sched_w [NDUT][8];
  int          cyc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("valid_d%0d_c%0d", k, cyc), 72'(ov[k]), 72'(sched_v[k][cyc % 8]));
      if (sched_v[k][cyc % 8]) out_m[k] = sched_w[k][cyc % 8];
      sched_v[k][cyc % 8] = 1'b0;
      check($sformatf("word_d%0d_c%0d", k, cyc), {ot[k], od[k]}, out_m[k]);
      check($sformatf("err_d%0d_c%0d", k, cyc), 72'(oe[k]), 72'(err_m[k]));
    end
  endtask

  task automatic cycle(input bit astb, input bit rd, input bit wr,
                       input logic [63:0] ad, input logic [7:0] tg);
    i_astb = astb; i_rd = rd; i_wr = wr; i_ad = ad; i_tag = tg;
    for (int k = 0; k < NDUT; k++) begin
      int mask;
      int eff;
      mask = (1 << AW_K[k]) - 1;
      eff  = astb ? int'(ad[15:0]) & mask : addr_m[k];
      if (rd && wr) begin
        err_m[k]  = 1'b1;
        addr_m[k] = eff;
      end else if (wr) begin
        mm[k][eff] = {tg, ad};
        addr_m[k]  = (eff + 1) & mask;
      end else if (rd) begin
        sched_v[k][(cyc + 1 + LAT_K[k]) % 8] = 1'b1;
        sched_w[k][(cyc + 1 + LAT_K[k]) % 8] = mm[k][eff];
        addr_m[k] = (eff + 1) & mask;
      end else begin
        addr_m[k] = eff;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    $display("cyc %0d astb %0b rd %0b wr %0b ad %h tag %h", cyc, astb, rd, wr, ad, tg);
    check_outputs();
    i_astb = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      addr_m[k] = 0;
      err_m[k]  = 1'b0;
      out_m[k]  = '0;
      for (int s = 0; s < 8; s++) sched_v[k][s] = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string name);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_word_d%0d", name, k), {ot[k], od[k]}, 72'h0);
      check($sformatf("%s_valid_d%0d", name, k), 72'(ov[k]), 72'h0);
      check($sformatf("%s_err_d%0d", name, k), 72'(oe[k]), 72'h0);
    end
  endtask

  initial begin
    logic [71:0] w;
    logic [63:0] ad;

    // Preload storage and model with random contents
    for (int i = 0; i < 65536; i++) begin
      w = {8'($urandom), $urandom, $urandom};
      mm[0][i] = w; mm[1][i] = w;
      d0.u_array.mem[i] = w;
      d1.u_array.mem[i] = w;
    end
    for (int i = 0; i < 16; i++) begin
      w = {8'($urandom), $urandom, $urandom};
      mm[2][i] = w;
      d2.u_array.mem[i] = w;
    end
    w = {8'h3C, 64'h0123_4567_89AB_CDEF};
    for (int k = 0; k < NDUT; k++) mm[k][5] = w;
    d0.u_array.mem[5] = w;
    d1.u_array.mem[5] = w;
    d2.u_array.mem[5] = w;

    model_reset();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_init");
    reset = 1'b0;

    // Preloaded word at address 5
    cycle(1'b1, 1'b0, 1'b0, 64'd5, 8'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    idle(4);
    check("addr5_d1", {ot[1], od[1]}, {8'h3C, 64'h0123_4567_89AB_CDEF});

    // Burst write 1..4 at 10, burst read back
    cycle(1'b1, 1'b0, 1'b0, 64'd10, 8'h0);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, 64'(i), 8'h11);
    cycle(1'b1, 1'b0, 1'b0, 64'd10, 8'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    idle(5);
    check("burst_last_d0", {ot[0], od[0]}, {8'h11, 64'd4});

    // Wrap-around on the AW=4 instance
    cycle(1'b1, 1'b0, 1'b0, 64'd15, 8'h0);
    cycle(1'b0, 1'b0, 1'b1, 64'hAAAA_0000_0000_000A, 8'hA5);
    cycle(1'b0, 1'b0, 1'b1, 64'hBBBB_0000_0000_000B, 8'hB6);
    check("wrap_mem15", d2.u_array.mem[15], {8'hA5, 64'hAAAA_0000_0000_000A});
    check("wrap_mem0", d2.u_array.mem[0], {8'hB6, 64'hBBBB_0000_0000_000B});

    // Strobe and write in the same cycle
    cycle(1'b1, 1'b0, 1'b1, 64'd7, 8'hFF);
    cycle(1'b1, 1'b0, 1'b0, 64'd7, 8'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    idle(4);
    check("strobe_wr_d2", {ot[2], od[2]}, {8'hFF, 64'd7});

    // Conflicting request: sticky error, no access, addr held (next read is addr 8)
    cycle(1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h55);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    idle(4);
    check("err_sticky_d0", 72'(oe[0]), 72'h1);

    // Asynchronous reset with a read in flight on the RD_LAT=3 instance
    cycle(1'b1, 1'b0, 1'b0, 64'd20, 8'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    idle(1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_state("rst_async");
    @(posedge clk);
    cyc++;
    #1;
    check_reset_state("rst_held");
    reset = 1'b0;
    idle(6);
    // Contents survive reset
    cycle(1'b1, 1'b0, 1'b0, 64'd20, 8'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    idle(4);

    // Randomised traffic on a small address window to exercise hits
    for (int n = 0; n < 300; n++) begin
      int op;
      bit astb;
      op   = $urandom_range(0, 3);
      astb = ($urandom_range(0, 2) == 0);
      ad   = {$urandom, $urandom};
      if (astb && op != 2) ad[15:0] = 16'($urandom_range(0, 31));
      if (astb && op == 2) ad[15:0] = 16'($urandom_range(0, 31));
      cycle(astb, op == 1 || op == 3, op == 2, ad, 8'($urandom));
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
